// File: rtl/grid_pkg.sv
// grid_pkg: shared definitions for the grid renderer.
//   COLOR_W          pixel colour width (4:4:4 RGB)
//   DEF_*_COLOR      default border and gap colours
//   region_e         per-axis classification of a scan coordinate
//   COORD_W, IDX_W   scan coordinate width and cell index width (up to 8 cells per axis)
package grid_pkg;

    localparam int COLOR_W = 12;
    localparam int COORD_W = 10;
    localparam int IDX_W   = 3;

    localparam logic [COLOR_W-1:0] DEF_BORDER_COLOR = 12'h94F;
    localparam logic [COLOR_W-1:0] DEF_GAP_COLOR    = 12'hFA0;

    typedef enum logic [1:0] {
        REG_BORDER = 2'd0,
        REG_GAP    = 2'd1,
        REG_CELL   = 2'd2
    } region_e;

endpackage

// File: rtl/grid_renderer_if.sv
// grid_renderer_if: scan-side bundle between the sync generator / game logic and the renderer.
//   x, y        scan position
//   videoOn     active-video qualifier for x, y
//   frameStart  one-cycle pulse per frame, during blanking
//   cellColors  cell (r,c) colour at bits [(r*COLS+c)*COLOR_W +: COLOR_W]
//   rgb         registered pixel colour returned by the renderer
// There is no valid/ready pair: x, y and videoOn are accepted on every clock edge, the
// pipeline never stalls, and rgb carries a meaningful value every cycle (0 when videoOn was low).
interface grid_renderer_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    import grid_pkg::*;

    logic [COORD_W-1:0]              x;
    logic [COORD_W-1:0]              y;
    logic                            videoOn;
    logic                            frameStart;
    logic [ROWS*COLS*COLOR_W-1:0]    cellColors;
    logic [COLOR_W-1:0]              rgb;

    modport master (
        output x, y, videoOn, frameStart, cellColors,
        input  rgb
    );

    modport slave (
        input  x, y, videoOn, frameStart, cellColors,
        output rgb
    );

endinterface

// File: rtl/grid_axis_locate.sv
// grid_axis_locate: classifies one scan coordinate as border, gap or cell k along one axis.
//   pos     scan coordinate
//   region  REG_BORDER / REG_GAP / REG_CELL
//   idx     cell index along the axis (0 unless region is REG_CELL)
// Purely combinational; the caller registers the outputs.
module grid_axis_locate
    import grid_pkg::*;
#(
    parameter int ORIGIN = 110,
    parameter int N      = 4,
    parameter int CELL   = 100,
    parameter int GAP    = 4
) (
    input  logic [COORD_W-1:0] pos,
    output region_e            region,
    output logic [IDX_W-1:0]   idx
);

    localparam int P = GAP + CELL;

    if (N < 1 || N > 8) begin : g_count_err
        $error("grid_axis_locate: cell count must be 1..8");
    end
    if (ORIGIN + N*P + GAP > 1023) begin : g_extent_err
        $error("grid_axis_locate: grid extent exceeds 1023");
    end

    localparam logic [10:0] LO = 11'(ORIGIN);
    localparam logic [10:0] HI = 11'(ORIGIN + N*P + GAP);

    // 11-bit compare so the bounds never wrap against a 10-bit coordinate.
    logic [10:0] p;
    assign p = {1'b0, pos};

    always_comb begin
        region = REG_BORDER;
        idx    = '0;
        if (p > LO && p <= HI) begin
            // Inside the grid extent: gap unless one of the cell windows claims it.
            region = REG_GAP;
            for (int k = 0; k < N; k++) begin
                if (p > 11'(ORIGIN + k*P + GAP) && p <= 11'(ORIGIN + (k+1)*P)) begin
                    region = REG_CELL;
                    idx    = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: maps the VGA scan position onto a ROWS x COLS board of coloured cells.
//   clk    pixel clock, rising edge
//   reset  asynchronous, active-high
//   bus    grid_renderer_if slave: x, y, videoOn, frameStart, cellColors in; rgb out
// Two register stages: stage 1 holds the per-axis region/index and videoOn, stage 2 holds rgb.
// Cell colours are snapshotted once per frame; a cell whose colour changed blinks
// (drawn inverted on alternate 2**BLINK_SHIFT-frame phases) for FLASH_FRAMES frames.
module grid_renderer
    import grid_pkg::*;
#(
    parameter int                 ROWS         = 4,
    parameter int                 COLS         = 4,
    parameter int                 CELL         = 100,
    parameter int                 GAP          = 4,
    parameter int                 ORIGIN_X     = 110,
    parameter int                 ORIGIN_Y     = 30,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = DEF_BORDER_COLOR,
    parameter logic [COLOR_W-1:0] GAP_COLOR    = DEF_GAP_COLOR,
    parameter int                 FLASH_FRAMES = 16,
    parameter int                 BLINK_SHIFT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    grid_renderer_if.slave   bus
);

    localparam int NCELL = ROWS * COLS;
    localparam int CNT_W = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_FRAMES);

    // ---------------- stage 1: per-axis location ----------------
    region_e            x_region_c, y_region_c;
    logic [IDX_W-1:0]   x_idx_c, y_idx_c;

    grid_axis_locate #(.ORIGIN(ORIGIN_X), .N(COLS), .CELL(CELL), .GAP(GAP)) u_locate_x (
        .pos    (bus.x),
        .region (x_region_c),
        .idx    (x_idx_c)
    );

    grid_axis_locate #(.ORIGIN(ORIGIN_Y), .N(ROWS), .CELL(CELL), .GAP(GAP)) u_locate_y (
        .pos    (bus.y),
        .region (y_region_c),
        .idx    (y_idx_c)
    );

    region_e            x_region_q, y_region_q;
    logic [IDX_W-1:0]   x_idx_q, y_idx_q;
    logic               von_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_region_q <= REG_BORDER;
            y_region_q <= REG_BORDER;
            x_idx_q    <= '0;
            y_idx_q    <= '0;
            von_q      <= 1'b0;
        end else begin
            x_region_q <= x_region_c;
            y_region_q <= y_region_c;
            x_idx_q    <= x_idx_c;
            y_idx_q    <= y_idx_c;
            von_q      <= bus.videoOn;
        end
    end

    // ---------------- snapshot and flash counters ----------------
    // The colours seen on a frameStart edge are parked in pend_q and committed one edge
    // later. Stage 2 reads the snapshot one edge after stage 1 captured the pixel, so this
    // keeps the pixel captured on the frameStart edge on the old snapshot.
    logic [COLOR_W-1:0] pend_q [NCELL];
    logic               pend_v_q;
    logic [COLOR_W-1:0] snap_q [NCELL];
    logic [CNT_W-1:0]   cnt_q  [NCELL];
    logic               primed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v_q <= 1'b0;
            primed_q <= 1'b0;
            for (int i = 0; i < NCELL; i++) begin
                pend_q[i] <= '0;
                snap_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            pend_v_q <= bus.frameStart;
            if (bus.frameStart) begin
                for (int i = 0; i < NCELL; i++) begin
                    pend_q[i] <= bus.cellColors[i*COLOR_W +: COLOR_W];
                end
            end
            if (pend_v_q) begin
                // The first commit after reset only fills the snapshot; nothing blinks.
                primed_q <= 1'b1;
                for (int i = 0; i < NCELL; i++) begin
                    snap_q[i] <= pend_q[i];
                    if (primed_q && pend_q[i] != snap_q[i]) begin
                        cnt_q[i] <= CNT_LOAD;
                    end else if (cnt_q[i] != '0) begin
                        cnt_q[i] <= cnt_q[i] - 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stage 2: colour select ----------------
    int                 sel_idx;
    logic [COLOR_W-1:0] sel_col;
    logic [CNT_W-1:0]   sel_cnt;
    logic [CNT_W-1:0]   sel_sh;
    logic               sel_inv;
    logic [COLOR_W-1:0] pix_c;
    logic [COLOR_W-1:0] rgb_q;

    assign sel_idx = int'(y_idx_q) * COLS + int'(x_idx_q);

    always_comb begin
        sel_col = '0;
        sel_cnt = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (i == sel_idx) begin
                sel_col = snap_q[i];
                sel_cnt = cnt_q[i];
            end
        end
        sel_sh  = sel_cnt >> BLINK_SHIFT;
        sel_inv = (sel_cnt != '0) && sel_sh[0];

        pix_c = GAP_COLOR;
        if (!von_q) begin
            pix_c = '0;
        end else if (x_region_q == REG_BORDER || y_region_q == REG_BORDER) begin
            pix_c = BORDER_COLOR;
        end else if (x_region_q == REG_CELL && y_region_q == REG_CELL) begin
            pix_c = sel_inv ? ~sel_col : sel_col;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= pix_c;
        end
    end

    assign bus.rgb = rgb_q;

endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: bench for grid_renderer. dut1 uses the default 4x4 geometry and is
// tracked every cycle against a reference model; dut2 (2x3, CELL=20, GAP=2) is checked
// against fixed vectors only.
module tb_grid_renderer;
    import grid_pkg::*;

    localparam int ROWS = 4, COLS = 4, NC = 16;
    localparam int CELL = 100, GAP = 4, OX = 110, OY = 30;
    localparam int FF = 16, BS = 2;
    localparam int NC2 = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    grid_renderer_if #(.ROWS(4), .COLS(4)) bus1 ();
    grid_renderer_if #(.ROWS(2), .COLS(3)) bus2 ();

    grid_renderer dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    grid_renderer #(.ROWS(2), .COLS(3), .CELL(20), .GAP(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];
    logic [11:0] cc1 [NC];

    // Reference model: snapshot, frames-left-to-blink, primed.
    logic [11:0] m_snap [NC];
    int          m_left [NC];
    bit          m_primed;

    typedef struct {
        int          x;
        int          y;
        bit          von;
        logic [11:0] e1;
        logic [11:0] e2;
    } vec_t;
    vec_t vecs [24];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 border, 1 gap, 2 cell
    function automatic void locate(input int p, input int origin, input int n,
                                   output int kind, output int idx);
        int rel, span;
        rel  = p - origin - 1;
        span = n * (CELL + GAP);
        idx  = 0;
        if (rel < 0 || rel >= span + GAP) kind = 0;
        else if (rel >= span) kind = 1;
        else begin
            idx  = rel / (CELL + GAP);
            kind = (rel % (CELL + GAP) < GAP) ? 1 : 2;
        end
    endfunction

    function automatic logic [11:0] model_pixel(input int x, input int y, input bit von);
        int kx, ix, ky, iy, c;
        logic [11:0] col;
        if (!von) return 12'h000;
        locate(x, OX, COLS, kx, ix);
        locate(y, OY, ROWS, ky, iy);
        if (kx == 0 || ky == 0) return 12'h94F;
        if (kx == 1 || ky == 1) return 12'hFA0;
        c   = iy * COLS + ix;
        col = m_snap[c];
        if (m_left[c] != 0 && ((m_left[c] / (2 ** BS)) % 2) == 1) col = ~col;
        return col;
    endfunction

    function automatic void model_frame();
        for (int i = 0; i < NC; i++) begin
            if (m_primed && cc1[i] != m_snap[i]) m_left[i] = FF;
            else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
            m_snap[i] = cc1[i];
        end
        m_primed = 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_snap[i] = 12'h000;
            m_left[i] = 0;
        end
        m_primed = 1'b0;
        exp_q.delete();
        exp_q.push_back(12'h000);  // rgb one edge after release comes from cleared stage 1
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int x, input int y, input bit von, input bit fs);
        logic [11:0] e;
        bus1.x = 10'(x);  bus1.y = 10'(y);  bus1.videoOn = von;  bus1.frameStart = fs;
        bus2.x = 10'(x);  bus2.y = 10'(y);  bus2.videoOn = von;  bus2.frameStart = fs;
        for (int i = 0; i < NC; i++) bus1.cellColors[i*12 +: 12] = cc1[i];
        @(posedge clk);
        e = model_pixel(x, y, von);  // pixel on a frameStart edge sees the old snapshot
        if (fs) model_frame();
        exp_q.push_back(e);
        #1;
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            check("sb_rgb", bus1.rgb, e);
        end
    endtask

    task automatic frame();
        step(0, 0, 1'b0, 1'b1);
    endtask

    task automatic hold(input int x, input int y, input bit von, input logic [11:0] e1,
                        input bit chk2, input logic [11:0] e2, input string name);
        step(x, y, von, 1'b0);
        step(x, y, von, 1'b0);
        check({name, "_dut1"}, bus1.rgb, e1);
        if (chk2) check({name, "_dut2"}, bus2.rgb, e2);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_dut1", bus1.rgb, 12'h000);
        check("reset_async_dut2", bus2.rgb, 12'h000);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic random_phase(input int cycles);
        bit fs;
        for (int n = 0; n < cycles; n++) begin
            if ($urandom_range(0, 199) == 0) cc1[$urandom_range(0, NC-1)] = 12'($urandom);
            fs = ($urandom_range(0, 39) == 0);
            if (fs && $urandom_range(0, 1) == 1) cc1[$urandom_range(0, NC-1)] = 12'($urandom);
            step($urandom_range(100, 540), $urandom_range(20, 460),
                 $urandom_range(0, 7) != 0, fs);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int left;
        logic [11:0] e;

        vecs[0]  = '{110, 100, 1'b1, 12'h94F, 12'h94F};
        vecs[1]  = '{111, 100, 1'b1, 12'hFA0, 12'h94F};
        vecs[2]  = '{114, 100, 1'b1, 12'hFA0, 12'h94F};
        vecs[3]  = '{115, 100, 1'b1, 12'h123, 12'h94F};
        vecs[4]  = '{214, 100, 1'b1, 12'h123, 12'h94F};
        vecs[5]  = '{215, 100, 1'b1, 12'hFA0, 12'h94F};
        vecs[6]  = '{530, 100, 1'b1, 12'hFA0, 12'h94F};
        vecs[7]  = '{531, 100, 1'b1, 12'h94F, 12'h94F};
        vecs[8]  = '{150,  30, 1'b1, 12'h94F, 12'h94F};
        vecs[9]  = '{150,  31, 1'b1, 12'hFA0, 12'hFA0};
        vecs[10] = '{150,  35, 1'b1, 12'h123, 12'h5A5};
        vecs[11] = '{150, 450, 1'b1, 12'hFA0, 12'h94F};
        vecs[12] = '{150, 451, 1'b1, 12'h94F, 12'h94F};
        vecs[13] = '{150,  60, 1'b0, 12'h000, 12'h000};
        vecs[14] = '{178,  40, 1'b1, 12'h123, 12'hFA0};
        vecs[15] = '{179,  40, 1'b1, 12'h123, 12'h94F};
        vecs[16] = '{120,  40, 1'b1, 12'h123, 12'h5A5};
        vecs[17] = '{112,  40, 1'b1, 12'hFA0, 12'hFA0};
        vecs[18] = '{150,  75, 1'b1, 12'h123, 12'hFA0};
        vecs[19] = '{150,  77, 1'b1, 12'h123, 12'h94F};
        vecs[20] = '{133,  40, 1'b1, 12'h123, 12'hFA0};
        vecs[21] = '{132,  52, 1'b1, 12'h123, 12'h5A5};
        vecs[22] = '{  0,   0, 1'b1, 12'h94F, 12'h94F};
        vecs[23] = '{1023, 1023, 1'b1, 12'h94F, 12'h94F};

        for (int i = 0; i < NC; i++) cc1[i] = 12'h000;
        bus1.x = '0; bus1.y = '0; bus1.videoOn = 1'b0; bus1.frameStart = 1'b0; bus1.cellColors = '0;
        bus2.x = '0; bus2.y = '0; bus2.videoOn = 1'b0; bus2.frameStart = 1'b0;
        bus2.cellColors = {NC2{12'h5A5}};

        // Power-on reset, then two-clock latency of a border pixel.
        repeat (3) @(posedge clk);
        #3;
        check("reset_rgb", bus1.rgb, 12'h000);
        reset = 1'b0;
        model_reset();
        step(50, 50, 1'b1, 1'b0);
        check("latency_c1", bus1.rgb, 12'h000);
        step(50, 50, 1'b1, 1'b0);
        check("latency_c2", bus1.rgb, 12'h94F);

        // Random scan with random colour changes and frames.
        random_phase(2000);

        // Reset in the middle of a line.
        hold(50, 50, 1'b1, 12'h94F, 1'b1, 12'h94F, "pre_reset");
        do_reset();
        step(50, 50, 1'b1, 1'b0);
        check("post_reset_c1", bus1.rgb, 12'h000);
        step(50, 50, 1'b1, 1'b0);
        check("post_reset_c2", bus1.rgb, 12'h94F);

        // First frame after reset with nonzero colours only primes: no blinking.
        for (int i = 0; i < NC; i++) cc1[i] = 12'h123;
        frame();
        for (int f = 0; f < 3; f++) begin
            hold(150, 60, 1'b1, 12'h123, 1'b1, 12'h5A5, "no_blink_first");
            frame();
        end

        // Geometry vectors on both instances.
        foreach (vecs[i]) begin
            hold(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].e1, 1'b1, vecs[i].e2,
                 $sformatf("vec%0d", i));
        end

        // Cell indexing, and colour changes without frameStart stay invisible.
        cc1[2*COLS + 3] = 12'hABC;
        frame();
        hold(500, 250, 1'b1, 12'hABC, 1'b1, 12'h94F, "cell_2_3");
        cc1[2*COLS + 3] = 12'h111;
        hold(500, 250, 1'b1, 12'hABC, 1'b0, 12'h000, "no_fs_invisible");

        // Pixel captured on the frameStart edge still uses the old snapshot.
        cc1[0] = 12'h777;
        step(150, 60, 1'b1, 1'b1);
        step(150, 60, 1'b1, 1'b0);
        check("snap_same_edge", bus1.rgb, 12'h123);
        step(150, 60, 1'b1, 1'b0);
        check("snap_next_edge", bus1.rgb, 12'h777);

        // Flash sequence on cell (0,0).
        do_reset();
        for (int i = 0; i < NC; i++) cc1[i] = 12'h000;
        frame();
        hold(150, 60, 1'b1, 12'h000, 1'b0, 12'h000, "flash_primed");
        cc1[0] = 12'hF00;
        for (int j = 1; j <= 20; j++) begin
            frame();
            left = (j <= FF) ? FF + 1 - j : 0;
            e = (left != 0 && ((left / 4) % 2) == 1) ? 12'h0FF : 12'hF00;
            hold(150, 60, 1'b1, e, 1'b0, 12'h000, $sformatf("flash_frame%0d", j));
        end

        random_phase(1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
